// File: rtl/vdc_pkg.sv
// vdc_pkg: shared types for the VDC pixel generator.
//   rgbi_t  - 4-bit RGBI colour
//   attr_t  - attribute byte: [7] reserved, [6] reverse, [5] underline, [4] blink, [3:0] RGBI
//   cmode_t - cursor mode: ON, OFF, blink at 1/16 rate, blink at 1/30 rate
package vdc_pkg;
   typedef logic [3:0] rgbi_t;
   typedef struct packed {
      logic  rsvd;
      logic  rvs;
      logic  ul;
      logic  blink;
      rgbi_t color;
   } attr_t;
   typedef enum logic [1:0] {
      CM_ON      = 2'b00,
      CM_OFF     = 2'b01,
      CM_BLINK16 = 2'b10,
      CM_BLINK30 = 2'b11
   } cmode_t;
endpackage

// File: rtl/vdc_attr_merge.sv
// vdc_attr_merge: combinational pixel priority and colour selection.
//   pix_base              - raw pixel bit from the shifter
//   attr, cursor          - attribute byte and cursor flag of the current column
//   line, blink           - current row line and blink phases
//   reg_*                 - register controls (atr, rvs, cm, cs, ce, ul, fg, bg)
//   hVisible..vblank      - visibility and blanking
//   rgbi_next             - colour to register on the next pixel enable
// Attribute handling is compiled in only when VDC_ATTR_EN is defined.
module vdc_attr_merge
   import vdc_pkg::*;
(
   input  logic       pix_base,
   input  attr_t      attr,
   input  logic       cursor,
   input  logic [4:0] line,
   input  logic [1:0] blink,
   input  logic       reg_atr,
   input  logic       reg_rvs,
   input  logic [1:0] reg_cm,
   input  logic [4:0] reg_cs,
   input  logic [4:0] reg_ce,
   input  logic [4:0] reg_ul,
   input  rgbi_t      reg_fg,
   input  rgbi_t      reg_bg,
   input  logic       hVisible,
   input  logic       vVisible,
   input  logic       hblank,
   input  logic       vblank,
   output rgbi_t      rgbi_next
);
   logic  cur_gate, cur_on, pix_attr, rvs_attr, pix;
   rgbi_t fg;
`ifdef VDC_ATTR_EN
   logic unused_rsvd;
   assign unused_rsvd = attr.rsvd;
`else
   logic unused_attr;
   assign unused_attr = ^{attr, reg_atr, reg_ul};
`endif
   always_comb begin
      cur_gate = cmode_t'(reg_cm) == CM_ON      ? 1'b1 :
                 cmode_t'(reg_cm) == CM_BLINK16 ? blink[0] :
                 cmode_t'(reg_cm) == CM_BLINK30 ? blink[1] : 1'b0;
      cur_on = cursor && line >= reg_cs && line <= reg_ce && cur_gate;
`ifdef VDC_ATTR_EN
      // blink-off overrides the forced underline, so it is tested first
      pix_attr = (reg_atr && attr.blink && blink[1]) ? 1'b0 :
                 (reg_atr && attr.ul && line == reg_ul) ? 1'b1 : pix_base;
      rvs_attr = reg_atr && attr.rvs;
      fg = reg_atr ? attr.color : reg_fg;
`else
      pix_attr = pix_base;
      rvs_attr = 1'b0;
      fg = reg_fg;
`endif
      pix = pix_attr ^ rvs_attr ^ cur_on ^ reg_rvs;
      rgbi_next = (hblank || vblank) ? 4'h0 :
                  !(hVisible && vVisible) ? reg_bg :
                  pix ? fg : reg_bg;
   end
endmodule

// File: rtl/vdc_pixelgen.sv
// vdc_pixelgen: VDC pixel generator -- column staging, pixel shifter, registered RGBI output.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   enable0                      - pixel-clock enable
//   newCol/endCol/newLine        - timing strobes
//   hVisible/vVisible/hblank/vblank - visibility and blanking
//   blink, line                  - blink phases, current row line
//   reg_*                        - register controls
//   data_valid/bitmap/attr/cursor - column data from the fetch unit
//   rgbi, underflow              - pixel colour, sticky missing-data flag
// Define VDC_ATTR_EN to compile in the attribute path.
module vdc_pixelgen
   import vdc_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable0,
   input  logic       newCol,
   input  logic       endCol,
   input  logic       newLine,
   input  logic       hVisible,
   input  logic       vVisible,
   input  logic       hblank,
   input  logic       vblank,
   input  logic [1:0] blink,
   input  logic [4:0] line,
   input  logic [3:0] reg_cdh,
   input  logic [3:0] reg_fg,
   input  logic [3:0] reg_bg,
   input  logic       reg_rvs,
   input  logic       reg_atr,
   input  logic       reg_semi,
   input  logic [1:0] reg_cm,
   input  logic [4:0] reg_cs,
   input  logic [4:0] reg_ce,
   input  logic [4:0] reg_ul,
   input  logic       data_valid,
   input  logic [7:0] bitmap,
   input  logic [7:0] attr,
   input  logic       cursor,
   output logic [3:0] rgbi,
   output logic       underflow
);
   logic [7:0] stg_bm, sh_bm;
   logic       stg_cur, sh_cur, stage_full, pix_base;
   logic [3:0] idx;
   attr_t      sh_attr;
   rgbi_t      rgbi_next;
   logic       col_load;
   assign col_load = enable0 && newCol;
`ifdef VDC_ATTR_EN
   attr_t stg_attr;
   logic  unused_in;
   assign unused_in = endCol;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         stg_attr <= '0;
         sh_attr  <= '0;
      end else begin
         if (data_valid) stg_attr <= attr_t'(attr);
         if (col_load) sh_attr <= stage_full ? stg_attr : '0;
      end
`else
   logic unused_in;
   assign unused_in = ^{endCol, attr};
   assign sh_attr = '0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         stg_bm     <= '0;
         stg_cur    <= 1'b0;
         sh_bm      <= '0;
         sh_cur     <= 1'b0;
         stage_full <= 1'b0;
         idx        <= 4'hF;
         underflow  <= 1'b0;
         rgbi       <= '0;
      end else begin
         if (data_valid) begin
            stg_bm  <= bitmap;
            stg_cur <= cursor;
         end
         // fresh data arriving with the transfer stays staged for the next column
         stage_full <= data_valid ? 1'b1 : col_load ? 1'b0 : stage_full;
         if (col_load) begin
            sh_bm  <= stage_full ? stg_bm : '0;
            sh_cur <= stage_full && stg_cur;
            idx    <= '0;
         end else if (enable0) begin
            idx <= idx == 4'hF ? idx : idx + 4'd1;
         end
         underflow <= (col_load && !stage_full) ? 1'b1 :
                      (enable0 && newLine && !vVisible) ? 1'b0 : underflow;
         if (enable0) rgbi <= rgbi_next;
      end
   // columns wider than 8 either repeat bit 0 (semigraphics) or show a gap
   assign pix_base = idx < 4'd8 ? sh_bm[3'd7 - idx[2:0]] :
                     idx <= reg_cdh ? (reg_semi & sh_bm[0]) : 1'b0;
   vdc_attr_merge u_merge (
      .pix_base (pix_base),
      .attr     (sh_attr),
      .cursor   (sh_cur),
      .line     (line),
      .blink    (blink),
      .reg_atr  (reg_atr),
      .reg_rvs  (reg_rvs),
      .reg_cm   (reg_cm),
      .reg_cs   (reg_cs),
      .reg_ce   (reg_ce),
      .reg_ul   (reg_ul),
      .reg_fg   (reg_fg),
      .reg_bg   (reg_bg),
      .hVisible (hVisible),
      .vVisible (vVisible),
      .hblank   (hblank),
      .vblank   (vblank),
      .rgbi_next(rgbi_next)
   );
endmodule

// File: tb/tb_vdc_pixelgen.sv
// tb_vdc_pixelgen: scoreboard bench for vdc_pixelgen.
module tb_vdc_pixelgen;
   logic       clk = 1'b0;
   logic       reset_n, enable0, newCol, endCol, newLine;
   logic       hVisible, vVisible, hblank, vblank;
   logic [1:0] blink;
   logic [4:0] line;
   logic [3:0] reg_cdh, reg_fg, reg_bg;
   logic       reg_rvs, reg_atr, reg_semi;
   logic [1:0] reg_cm;
   logic [4:0] reg_cs, reg_ce, reg_ul;
   logic       data_valid, cursor;
   logic [7:0] bitmap, attr;
   logic [3:0] rgbi;
   logic       underflow;
   logic [3:0] q_exp[$];
   logic [3:0] obs[$];
   int         nvec = 0;
   int         nmis = 0;

   always #5 clk = ~clk;

   vdc_pixelgen dut (
      .clk(clk), .reset_n(reset_n), .enable0(enable0), .newCol(newCol), .endCol(endCol),
      .newLine(newLine), .hVisible(hVisible), .vVisible(vVisible), .hblank(hblank),
      .vblank(vblank), .blink(blink), .line(line), .reg_cdh(reg_cdh), .reg_fg(reg_fg),
      .reg_bg(reg_bg), .reg_rvs(reg_rvs), .reg_atr(reg_atr), .reg_semi(reg_semi),
      .reg_cm(reg_cm), .reg_cs(reg_cs), .reg_ce(reg_ce), .reg_ul(reg_ul),
      .data_valid(data_valid), .bitmap(bitmap), .attr(attr), .cursor(cursor),
      .rgbi(rgbi), .underflow(underflow)
   );

   // Optionally stage one column, strobe newCol (optionally with new data coinciding),
   // then capture rgbi after each of n following pixel enables.
   task automatic drive_col(input logic [7:0] bm, input logic [7:0] at, input logic cur,
                            input bit stage, input bit coin, input logic [7:0] cbm, input int n);
      obs.delete();
      @(negedge clk);
      if (stage) begin
         data_valid = 1'b1; bitmap = bm; attr = at; cursor = cur;
      end
      @(negedge clk);
      data_valid = coin; bitmap = cbm; newCol = 1'b1;
      @(negedge clk);
      data_valid = 1'b0; newCol = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         obs.push_back(rgbi);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      nvec++; if (rgbi !== 4'h0) begin nmis++; $display("FAIL reset_rgbi got=%h exp=0", rgbi); end
      nvec++; if (underflow !== 1'b0) begin nmis++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] e, g;
      reg_fg = 4'hF; reg_bg = 4'h0; reg_cdh = 4'd8; reg_atr = 1'b0;
      foreach (q_exp[i]) q_exp.delete(i);
      q_exp = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
      drive_col(8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 9);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL basic px%0d got=%h exp=%h", k, g, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e, g;
      q_exp = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
      drive_col(8'hF0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0F, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL b2b_first px%0d got=%h exp=%h", k, g, e); end
      end
      q_exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
      drive_col(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL b2b_second px%0d got=%h exp=%h", k, g, e); end
      end
      nvec++; if (underflow !== 1'b0) begin nmis++; $display("FAIL b2b_underflow got=%b exp=0", underflow); end
   endtask

   task automatic test_cursor();
      logic [3:0] e, g;
      reg_bg = 4'h2; reg_cs = 5'd0; reg_ce = 5'd7; line = 5'd3; reg_cm = 2'b00;
      for (int k = 0; k < 8; k++) q_exp.push_back(4'hF);
      drive_col(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL cursor_on px%0d got=%h exp=%h", k, g, e); end
      end
      reg_cm = 2'b01;
      for (int k = 0; k < 8; k++) q_exp.push_back(4'h2);
      drive_col(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL cursor_off px%0d got=%h exp=%h", k, g, e); end
      end
   endtask

   task automatic test_semi();
      logic [3:0] e, g;
      reg_semi = 1'b1; reg_cdh = 4'd10;
      q_exp = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 4'h2, 4'h2};
      drive_col(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 13);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL semi px%0d got=%h exp=%h", k, g, e); end
      end
      reg_semi = 1'b0; reg_cdh = 4'd8;
   endtask

   task automatic test_attr();
      logic [3:0] e, g;
      reg_atr = 1'b1; reg_ul = 5'd3; line = 5'd3;
`ifdef VDC_ATTR_EN
      for (int k = 0; k < 8; k++) q_exp.push_back(4'h4);
`else
      for (int k = 0; k < 8; k++) q_exp.push_back(4'h2);
`endif
      drive_col(8'h00, 8'h24, 1'b0, 1'b1, 1'b0, 8'h00, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL attr_ul px%0d got=%h exp=%h", k, g, e); end
      end
      reg_atr = 1'b0; reg_ul = 5'd31; attr = 8'h00;
   endtask

   task automatic test_blank();
      logic [3:0] e, g;
      hblank = 1'b1;
      q_exp = '{4'h0, 4'h0, 4'h0};
      drive_col(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL hblank px%0d got=%h exp=%h", k, g, e); end
      end
      hblank = 1'b0; hVisible = 1'b0;
      q_exp = '{4'h2, 4'h2, 4'h2};
      drive_col(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL invisible px%0d got=%h exp=%h", k, g, e); end
      end
      hVisible = 1'b1;
   endtask

   task automatic test_underflow();
      logic [3:0] e, g;
      for (int k = 0; k < 8; k++) q_exp.push_back(4'h2);
      drive_col(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL underflow_px px%0d got=%h exp=%h", k, g, e); end
      end
      nvec++; if (underflow !== 1'b1) begin nmis++; $display("FAIL underflow_set got=%b exp=1", underflow); end
      @(negedge clk); newLine = 1'b1;
      @(negedge clk); newLine = 1'b0;
      nvec++; if (underflow !== 1'b1) begin nmis++; $display("FAIL underflow_visline got=%b exp=1", underflow); end
      vVisible = 1'b0; newLine = 1'b1;
      @(negedge clk); newLine = 1'b0; vVisible = 1'b1;
      nvec++; if (underflow !== 1'b0) begin nmis++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] e, g;
      drive_col(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2);
      nvec++; if (underflow !== 1'b1) begin nmis++; $display("FAIL mid_pre_underflow got=%b exp=1", underflow); end
      @(negedge clk); data_valid = 1'b1; bitmap = 8'hFF; cursor = 1'b0;
      @(negedge clk); newCol = 1'b1;
      @(negedge clk); newCol = 1'b0; data_valid = 1'b0;
      @(posedge clk); #1;
      nvec++; if (rgbi !== 4'hF) begin nmis++; $display("FAIL mid_pre_rgbi got=%h exp=F", rgbi); end
      #2 reset_n = 1'b0;
      #1;
      nvec++; if (rgbi !== 4'h0) begin nmis++; $display("FAIL mid_reset_rgbi got=%h exp=0", rgbi); end
      nvec++; if (underflow !== 1'b0) begin nmis++; $display("FAIL mid_reset_underflow got=%b exp=0", underflow); end
      @(negedge clk); reset_n = 1'b1;
      q_exp = '{4'h2, 4'h2, 4'h2, 4'h2};
      drive_col(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4);
      for (int k = 0; q_exp.size() > 0; k++) begin
         e = q_exp.pop_front(); g = obs.size() > 0 ? obs.pop_front() : 4'hx;
         nvec++; if (g !== e) begin nmis++; $display("FAIL post_reset px%0d got=%h exp=%h", k, g, e); end
      end
      nvec++; if (underflow !== 1'b1) begin nmis++; $display("FAIL post_reset_underflow got=%b exp=1", underflow); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      enable0 = 1'b1; newCol = 1'b0; endCol = 1'b0; newLine = 1'b0;
      hVisible = 1'b1; vVisible = 1'b1; hblank = 1'b0; vblank = 1'b0;
      blink = 2'b00; line = 5'd3; reg_cdh = 4'd8; reg_fg = 4'hF; reg_bg = 4'h0;
      reg_rvs = 1'b0; reg_atr = 1'b0; reg_semi = 1'b0; reg_cm = 2'b01;
      reg_cs = 5'd0; reg_ce = 5'd7; reg_ul = 5'd31;
      data_valid = 1'b0; bitmap = 8'h00; attr = 8'h00; cursor = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_cursor();
      test_semi();
      test_attr();
      test_blank();
      test_underflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/vdc_pixelgen.md
VDC_PIXELGEN -- requirements
Module: vdc_pixelgen

Interface
REQ-001 Parameters: none; all behaviour is set by register inputs.
REQ-002 clk  in  1  system clock, single clock domain.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 enable0  in  1  pixel-clock enable; all state except reset advances only when high.
REQ-005 newCol, endCol, newLine  in  1 each  column and line strobes from clock generator.
REQ-006 hVisible, vVisible, hblank, vblank  in  1 each  visibility and blanking from clock generator.
REQ-007 blink  in  2  [0]=1/16 rate, [1]=1/30 rate.
REQ-008 line  in  5  current row line.
REQ-009 reg_cdh  in  4  displayed pixels per column (R22[3:0]); reg_fg, reg_bg  in  4 each  RGBI.
REQ-010 reg_rvs, reg_atr, reg_semi  in  1 each  reverse screen, attribute enable, semigraphics (R24/R25 bits).
REQ-011 reg_cm  in  2  cursor mode; reg_cs, reg_ce  in  5 each  cursor start/end line; reg_ul  in  5  underline line.
REQ-012 data_valid  in  1; bitmap  in  8; attr  in  8 (bit6 rvs, bit5 ul, bit4 blink, [3:0] RGBI); cursor  in  1  column is cursor position.
REQ-013 rgbi  out  4  pixel colour; underflow  out  1  sticky missing-data flag.

Function
REQ-014 Staging: on any clk with data_valid=1, latch bitmap/attr/cursor and set stage_full, enable0 not required.
REQ-015 On enable0&&newCol: if stage_full, move staging into shifter, clear stage_full, reset pixel index to 0; else load bitmap=0, attr=0, cursor=0 and set underflow.
REQ-016 data_valid coinciding with the newCol transfer: transfer takes old staging, new data stays staged (stage_full remains 1).
REQ-017 Each enable0: pixel index increments, saturating at 15; bitmap bit shown = bit (7-index) for index<8.
REQ-018 Index>=8 and index<=reg_cdh: pixel = bit0 if reg_semi else 0; index>reg_cdh: pixel = 0 (gap).
REQ-019 Cursor active: cursor && line>=reg_cs && line<=reg_ce && mode gate; cm 00 on, 01 off, 10 blink[0], 11 blink[1].
REQ-020 Priority: base -> (reg_atr&&ul&&line==reg_ul) force 1 -> (reg_atr&&blink-attr&&blink[1]) force 0 -> XOR attr rvs -> XOR cursor -> XOR reg_rvs.
REQ-021 Foreground = attr[3:0] if reg_atr else reg_fg; background = reg_bg.
REQ-022 Output: hblank|vblank -> rgbi=0; else !(hVisible&&vVisible) -> reg_bg; else fg/bg by pixel.
REQ-023 rgbi registered, updated only on enable0; latency exactly one enable0 after the pixel slot.
REQ-024 underflow clears only on reset or on enable0&&newLine&&!vVisible.

Reset
REQ-025 reset_n low: rgbi=0, underflow=0, stage_full=0, shifter/staging=0, index=15; takes effect immediately mid-line, release synchronous to clk.

Configuration
REQ-026 VDC_ATTR_EN defined: attribute path (REQ-020 ul/blink/rvs, REQ-021 colour) compiled in.
REQ-027 VDC_ATTR_EN undefined: attr input ignored, staging attr not stored, foreground = reg_fg, reg_atr has no effect.

Structure
REQ-028 Package vdc_pkg holds attribute bitfield typedef, cursor-mode enum (ON, OFF, BLINK16, BLINK30), RGBI typedef.
REQ-029 Sub-module vdc_attr_merge holds the combinational priority/colour logic of REQ-019..REQ-022.

Verification
REQ-030 bitmap=8'hA5, reg_atr=0, reg_fg=F, reg_bg=0, reg_cdh=8 -> rgbi F,0,F,0,0,F,0,F, then 0 for index 8.
REQ-031 No data_valid before newCol -> column all reg_bg, underflow=1 until next invisible newLine.
REQ-032 cursor=1, reg_cm=00, reg_cs=0, reg_ce=7, line=3, bitmap=8'h00 -> 8 pixels of fg; reg_cm=01 -> all bg.
REQ-033 reg_atr=1, attr=8'h24 (ul, RGBI=4), line==reg_ul, bitmap=0 -> 8 pixels rgbi=4.
REQ-034 reg_semi=1, reg_cdh=10, bitmap=8'h01 -> pixels 7..10 foreground, 11+ background.
REQ-035 reset_n low mid-column -> rgbi=0 same cycle, underflow=0, first column after release underflows unless data_valid seen.
